// File: rtl/boot_loader_pkg.sv
// Shared types and helpers for the power-on SRAM boot loader.
package boot_loader_pkg;

    localparam int MAX_CH    = 8;
    localparam int MAX_AW    = 32;
    localparam int LEN_BUS_W = MAX_CH * MAX_AW;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_VRD,
        ST_VCMP,
        ST_DONE,
        ST_FAIL
    } state_t;

    // Length of channel i from a packed length bus with aw-bit fields.
    function automatic logic [MAX_AW-1:0] len_of(input logic [LEN_BUS_W-1:0] lens,
                                                 input int aw, input int i);
        logic [LEN_BUS_W-1:0] sh;
        logic [MAX_AW-1:0]    mask;
        sh   = lens >> (i * aw);
        mask = (aw >= MAX_AW) ? '1 : ((32'd1 << aw) - 32'd1);
        return sh[MAX_AW-1:0] & mask;
    endfunction

    // ROM base address of channel i: total length of all lower channels.
    function automatic logic [MAX_AW-1:0] ch_base(input logic [LEN_BUS_W-1:0] lens,
                                                  input int aw, input int i);
        logic [MAX_AW-1:0] sum;
        sum = '0;
        for (int j = 0; j < MAX_CH; j++) begin
            if (j < i) sum = sum + len_of(lens, aw, j);
        end
        return sum;
    endfunction

    // First channel above i with a nonzero length, or nch when none is left.
    function automatic int next_ch(input logic [LEN_BUS_W-1:0] lens,
                                   input int aw, input int nch, input int i);
        int r;
        r = nch;
        for (int j = MAX_CH - 1; j >= 0; j--) begin
            if (j > i && j < nch && len_of(lens, aw, j) != '0) r = j;
        end
        return r;
    endfunction

endpackage

// File: rtl/boot_loader.sv
// Power-on loader: copies a flat ROM image into NUM_CH SRAM targets,
// one word at a time, with optional read-back verify and bounded retry.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int                       DATA_W    = 8,
    parameter int                       ADDR_W    = 17,
    parameter int                       NUM_CH    = 3,
    parameter logic [NUM_CH*ADDR_W-1:0] CH_LEN    = {NUM_CH{ADDR_W'(4096)}},
    parameter int                       ROM_WAIT  = 1,
    parameter int                       VERIFY    = 0,
    parameter int                       MAX_RETRY = 2
)(
    input  logic              CLK,
    input  logic              N_RST,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic              ROM_N_OE,
    input  logic [DATA_W-1:0] ROM_DATA,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DATA,
    output logic              SRAM_N_OE,
    input  logic [DATA_W-1:0] SRAM_DATA,
    output logic [NUM_CH-1:0] N_WE,
    output logic [2:0]        CH,
    output logic              N_BOOTED,
    output logic              ERROR
);

    localparam logic [LEN_BUS_W-1:0] LENS = LEN_BUS_W'(CH_LEN);
    localparam int WAIT_W  = (ROM_WAIT > 1) ? $clog2(ROM_WAIT) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t              state, state_nx;
    logic [WAIT_W-1:0]   wait_cnt, wait_nx;
    logic [RETRY_W-1:0]  retry_cnt, retry_nx;
    logic [ADDR_W-1:0]   rom_addr, rom_addr_nx;
    logic [ADDR_W-1:0]   addr, addr_nx;
    logic [DATA_W-1:0]   data, data_nx;
    logic [2:0]          ch, ch_nx;
    logic                advance;
    int                  nxt;

    logic                rom_n_oe_q, sram_n_oe_q, n_booted_q, error_q;
    logic [NUM_CH-1:0]   n_we_q;

    // Per-channel length table, padded so any 3-bit CH indexes safely.
    logic [ADDR_W-1:0]   len_tab [MAX_CH];

    for (genvar g = 0; g < MAX_CH; g++) begin : g_len
        if (g < NUM_CH) begin : g_on
            assign len_tab[g] = CH_LEN[g*ADDR_W +: ADDR_W];
        end else begin : g_off
            assign len_tab[g] = '0;
        end
    end

    // Next-state and datapath update for the word-copy sequence.
    always_comb begin
        state_nx    = state;
        wait_nx     = wait_cnt;
        retry_nx    = retry_cnt;
        rom_addr_nx = rom_addr;
        addr_nx     = addr;
        data_nx     = data;
        ch_nx       = ch;
        advance     = 1'b0;
        nxt         = 0;

        case (state)
            ST_IDLE: begin
                nxt = next_ch(LENS, ADDR_W, NUM_CH, -1);
                if (nxt >= NUM_CH) begin
                    state_nx = ST_DONE;
                end else begin
                    ch_nx       = 3'(nxt);
                    rom_addr_nx = ADDR_W'(ch_base(LENS, ADDR_W, nxt));
                    addr_nx     = '0;
                    wait_nx     = '0;
                    retry_nx    = '0;
                    state_nx    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // The ROM has had ROM_WAIT cycles with OE low; capture on the last one.
                if (wait_cnt == WAIT_W'(ROM_WAIT - 1)) begin
                    data_nx  = ROM_DATA;
                    wait_nx  = '0;
                    state_nx = ST_SETUP;
                end else begin
                    wait_nx = wait_cnt + WAIT_W'(1);
                end
            end
            ST_SETUP:  state_nx = ST_STROBE;
            ST_STROBE: state_nx = ST_HOLD;
            ST_HOLD: begin
                if (VERIFY != 0) state_nx = ST_VRD;
                else             advance  = 1'b1;
            end
            ST_VRD:    state_nx = ST_VCMP;
            ST_VCMP: begin
                if (SRAM_DATA == data) begin
                    advance = 1'b1;
                end else if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                    retry_nx = retry_cnt + RETRY_W'(1);
                    state_nx = ST_SETUP;
                end else begin
                    state_nx = ST_FAIL;
                end
            end
            ST_DONE:   state_nx = ST_DONE;
            ST_FAIL:   state_nx = ST_FAIL;
            default:   state_nx = ST_IDLE;
        endcase

        // Word advance; the ROM pointer runs on across channel boundaries.
        if (advance) begin
            wait_nx     = '0;
            retry_nx    = '0;
            rom_addr_nx = rom_addr + ADDR_W'(1);
            if (addr == len_tab[ch] - ADDR_W'(1)) begin
                addr_nx = '0;
                nxt     = next_ch(LENS, ADDR_W, NUM_CH, int'(ch));
                if (nxt >= NUM_CH) begin
                    state_nx = ST_DONE;
                end else begin
                    ch_nx    = 3'(nxt);
                    state_nx = ST_FETCH;
                end
            end else begin
                addr_nx  = addr + ADDR_W'(1);
                state_nx = ST_FETCH;
            end
        end
    end

    // State, datapath and registered strobes; strobes decode the next state
    // so every output comes straight from a flop.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            retry_cnt   <= '0;
            rom_addr    <= '0;
            addr        <= '0;
            data        <= '0;
            ch          <= '0;
            rom_n_oe_q  <= 1'b1;
            sram_n_oe_q <= 1'b1;
            n_we_q      <= '1;
            n_booted_q  <= 1'b1;
            error_q     <= 1'b0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= wait_nx;
            retry_cnt   <= retry_nx;
            rom_addr    <= rom_addr_nx;
            addr        <= addr_nx;
            data        <= data_nx;
            ch          <= ch_nx;
            rom_n_oe_q  <= (state_nx != ST_FETCH);
            sram_n_oe_q <= !(state_nx == ST_VRD || state_nx == ST_VCMP);
            n_we_q      <= (state_nx == ST_STROBE) ? ~(NUM_CH'(1) << ch_nx) : '1;
            n_booted_q  <= (state_nx != ST_DONE);
            error_q     <= (state_nx == ST_FAIL);
        end
    end

    assign ROM_ADDR  = rom_addr;
    assign ROM_N_OE  = rom_n_oe_q;
    assign ADDR      = addr;
    assign DATA      = data;
    assign SRAM_N_OE = sram_n_oe_q;
    assign N_WE      = n_we_q;
    assign CH        = ch;
    assign N_BOOTED  = n_booted_q;
    assign ERROR     = error_q;

    a_we_onehot: assert property (@(posedge CLK) disable iff (!N_RST)
        $onehot0(~n_we_q));
    a_we_excl: assert property (@(posedge CLK) disable iff (!N_RST)
        (n_we_q != '1) |-> (rom_n_oe_q && sram_n_oe_q));
    a_boot_err: assert property (@(posedge CLK) disable iff (!N_RST)
        !(!n_booted_q && error_q));

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: four configurations run side by side against a
// ROM/SRAM model, with expected results computed from channel lengths.
module tb_boot_loader;

    localparam int NK = 4;
    localparam int MR = 2;
    localparam int RW  [NK]    = '{1, 3, 1, 1};
    localparam int VF  [NK]    = '{0, 0, 0, 1};
    localparam int LEN [NK][3] = '{'{4, 3, 0}, '{4, 3, 0}, '{0, 2, 0}, '{4, 3, 0}};

    logic        CLK, N_RST;
    logic [16:0] rom_addr [NK];
    logic [16:0] addr     [NK];
    logic [7:0]  rom_data [NK];
    logic [7:0]  data     [NK];
    logic [7:0]  sram_data[NK];
    logic        rom_n_oe [NK];
    logic        sram_n_oe[NK];
    logic        n_booted [NK];
    logic        error    [NK];
    logic [2:0]  ch       [NK];
    logic [2:0]  n_we     [NK];
    logic [1:0]  we0, we1, we3;
    logic [2:0]  we2;

    assign n_we[0] = {1'b1, we0};
    assign n_we[1] = {1'b1, we1};
    assign n_we[2] = we2;
    assign n_we[3] = {1'b1, we3};

    boot_loader #(.NUM_CH(2), .CH_LEN({17'd3, 17'd4}), .ROM_WAIT(1), .VERIFY(0)) u_a (
        .CLK(CLK), .N_RST(N_RST), .ROM_ADDR(rom_addr[0]), .ROM_N_OE(rom_n_oe[0]),
        .ROM_DATA(rom_data[0]), .ADDR(addr[0]), .DATA(data[0]), .SRAM_N_OE(sram_n_oe[0]),
        .SRAM_DATA(sram_data[0]), .N_WE(we0), .CH(ch[0]), .N_BOOTED(n_booted[0]), .ERROR(error[0]));
    boot_loader #(.NUM_CH(2), .CH_LEN({17'd3, 17'd4}), .ROM_WAIT(3), .VERIFY(0)) u_b (
        .CLK(CLK), .N_RST(N_RST), .ROM_ADDR(rom_addr[1]), .ROM_N_OE(rom_n_oe[1]),
        .ROM_DATA(rom_data[1]), .ADDR(addr[1]), .DATA(data[1]), .SRAM_N_OE(sram_n_oe[1]),
        .SRAM_DATA(sram_data[1]), .N_WE(we1), .CH(ch[1]), .N_BOOTED(n_booted[1]), .ERROR(error[1]));
    boot_loader #(.NUM_CH(3), .CH_LEN({17'd0, 17'd2, 17'd0}), .ROM_WAIT(1), .VERIFY(0)) u_c (
        .CLK(CLK), .N_RST(N_RST), .ROM_ADDR(rom_addr[2]), .ROM_N_OE(rom_n_oe[2]),
        .ROM_DATA(rom_data[2]), .ADDR(addr[2]), .DATA(data[2]), .SRAM_N_OE(sram_n_oe[2]),
        .SRAM_DATA(sram_data[2]), .N_WE(we2), .CH(ch[2]), .N_BOOTED(n_booted[2]), .ERROR(error[2]));
    boot_loader #(.NUM_CH(2), .CH_LEN({17'd3, 17'd4}), .ROM_WAIT(1), .VERIFY(1), .MAX_RETRY(MR)) u_d (
        .CLK(CLK), .N_RST(N_RST), .ROM_ADDR(rom_addr[3]), .ROM_N_OE(rom_n_oe[3]),
        .ROM_DATA(rom_data[3]), .ADDR(addr[3]), .DATA(data[3]), .SRAM_N_OE(sram_n_oe[3]),
        .SRAM_DATA(sram_data[3]), .N_WE(we3), .CH(ch[3]), .N_BOOTED(n_booted[3]), .ERROR(error[3]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ROM / SRAM model state
    logic [7:0] rom_mem [16];
    logic [7:0] mem  [NK][8][8];
    int         wcnt [NK][8][8];
    int         fault_mode;   // 0 none, 1 corrupt first write ch0/addr1, 2 ch0/addr2 stuck at FF
    int         boot_edge[NK], err_edge[NK], viol[NK], n_str[NK], oe_run[NK];
    logic [16:0] first_rom[NK];
    int         st2;
    logic [2:0]  prev_we[NK], prev_ch[NK];
    logic [16:0] prev_addr[NK];
    logic [7:0]  prev_data[NK];

    int n_vec, n_bad;

    always_comb begin
        for (int k = 0; k < NK; k++) begin
            rom_data[k]  = rom_mem[rom_addr[k][3:0]];
            sram_data[k] = mem[k][ch[k]][addr[k][2:0]];
            if (k == 3 && fault_mode == 2 && ch[k] == 3'd0 && addr[k] == 17'd2)
                sram_data[k] = 8'hFF;
        end
    end

    typedef struct {
        int fault;
        int r3;
        int e0, e1, e2, e3;
        bit err3;
        int err_edge3;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int base_of(input int k, input int c);
        int s = 0;
        for (int j = 0; j < c; j++) s += LEN[k][j];
        return s;
    endfunction

    function automatic int per_word(input int k);
        return RW[k] + 3 + (VF[k] != 0 ? 2 : 0);
    endfunction

    function automatic int model_edge(input int k, input int r);
        return 1 + per_word(k) * base_of(k, 3) + r * (per_word(k) - RW[k]);
    endfunction

    task automatic chk_reset(input string tag);
        for (int k = 0; k < NK; k++)
            chk($sformatf("%s_reset_k%0d", tag, k),
                64'({rom_addr[k], addr[k], data[k], ch[k], rom_n_oe[k], sram_n_oe[k],
                     n_we[k], n_booted[k], error[k]}),
                64'({17'd0, 17'd0, 8'd0, 3'd0, 1'b1, 1'b1, 3'b111, 1'b1, 1'b0}));
    endtask

    task automatic monitor(input int e);
        for (int k = 0; k < NK; k++) begin
            int lows, c;
            lows = 0; c = 0;
            for (int b = 0; b < 3; b++) if (!n_we[k][b]) begin lows++; c = b; end
            if (lows > 1) viol[k]++;
            if (lows != 0 && (!rom_n_oe[k] || !sram_n_oe[k])) viol[k]++;
            if (lows != 0 && prev_we[k] != 3'b111) viol[k]++;
            if ((lows != 0 || prev_we[k] != 3'b111) &&
                (addr[k] != prev_addr[k] || data[k] != prev_data[k] || ch[k] != prev_ch[k])) viol[k]++;
            if (!n_booted[k] && error[k]) viol[k]++;
            if (VF[k] == 0 && !sram_n_oe[k]) viol[k]++;
            if (!rom_n_oe[k]) begin
                oe_run[k]++;
                if (ch[k] > 3'd2 || LEN[k][ch[k]] == 0) viol[k]++;
            end else begin
                if (oe_run[k] != 0 && oe_run[k] != RW[k]) viol[k]++;
                oe_run[k] = 0;
            end
            if (lows == 1) begin
                if (c != int'(ch[k])) viol[k]++;
                n_str[k]++;
                if (k == 3 && c == 0 && addr[k] == 17'd2) st2++;
                if (addr[k] < 17'd8) begin
                    if (k == 3 && fault_mode == 1 && c == 0 && addr[k] == 17'd1 && wcnt[k][c][addr[k][2:0]] == 0)
                        mem[k][c][addr[k][2:0]] = data[k] ^ 8'hA5;
                    else
                        mem[k][c][addr[k][2:0]] = data[k];
                    wcnt[k][c][addr[k][2:0]]++;
                end
            end
            if (!n_booted[k] && boot_edge[k] == 0) boot_edge[k] = e;
            if (error[k] && err_edge[k] == 0) err_edge[k] = e;
            if (e == 1) first_rom[k] = rom_addr[k];
            prev_we[k] = n_we[k]; prev_ch[k] = ch[k];
            prev_addr[k] = addr[k]; prev_data[k] = data[k];
        end
    endtask

    task automatic run_load(input int fault);
        int  tail;
        bit  all_done;
        fault_mode = fault;
        @(negedge CLK); N_RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk_reset("load");
        for (int k = 0; k < NK; k++) begin
            boot_edge[k] = 0; err_edge[k] = 0; viol[k] = 0; n_str[k] = 0; oe_run[k] = 0;
            first_rom[k] = '1;
            prev_we[k] = 3'b111; prev_ch[k] = '0; prev_addr[k] = '0; prev_data[k] = '0;
            for (int c = 0; c < 8; c++)
                for (int a = 0; a < 8; a++) begin mem[k][c][a] = 8'h00; wcnt[k][c][a] = 0; end
        end
        st2 = 0; tail = 0; all_done = 1'b0;
        N_RST = 1'b1;
        for (int e = 1; e <= 400; e++) begin
            @(posedge CLK); #1;
            monitor(e);
            all_done = 1'b1;
            for (int k = 0; k < NK; k++) if (boot_edge[k] == 0 && err_edge[k] == 0) all_done = 1'b0;
            if (all_done) tail++;
            if (tail == 12) break;
        end
        chk("load_done", 64'(all_done), 64'd1);
    endtask

    task automatic check_k(input int k, input int exp_edge, input int r, input bit exp_err,
                           input int exp_err_edge);
        chk($sformatf("k%0d_invariants", k), 64'(viol[k]), 64'd0);
        chk($sformatf("k%0d_rom_start", k), 64'(first_rom[k]), 64'd0);
        if (!exp_err) begin
            chk($sformatf("k%0d_boot_edge", k), 64'(boot_edge[k]), 64'(exp_edge));
            chk($sformatf("k%0d_error", k), 64'(err_edge[k]), 64'd0);
            chk($sformatf("k%0d_strobes", k), 64'(n_str[k]), 64'(base_of(k, 3) + r));
            for (int c = 0; c < 3; c++)
                for (int a = 0; a < LEN[k][c]; a++) begin
                    chk($sformatf("k%0d_mem_c%0d_a%0d", k, c, a), 64'(mem[k][c][a]),
                        64'(rom_mem[base_of(k, c) + a]));
                    chk($sformatf("k%0d_wcnt_c%0d_a%0d", k, c, a), 64'(wcnt[k][c][a]),
                        64'(1 + ((k == 3 && fault_mode == 1 && c == 0 && a == 1) ? 1 : 0)));
                end
        end else begin
            chk($sformatf("k%0d_err_edge", k), 64'(err_edge[k]), 64'(exp_err_edge));
            chk($sformatf("k%0d_no_boot", k), 64'(boot_edge[k]), 64'd0);
            chk($sformatf("k%0d_addr2_strobes", k), 64'(st2), 64'(MR + 1));
            chk($sformatf("k%0d_strobes", k), 64'(n_str[k]), 64'(2 + MR + 1));
            chk($sformatf("k%0d_final_flags", k), 64'({n_booted[k], error[k]}), 64'(2'b11));
        end
    endtask

    // Release reset, run until the abort point, then pull reset mid-cycle.
    task automatic mid_reset(input int mode, input int n);
        bit found;
        found = 1'b0;
        @(negedge CLK); N_RST = 1'b0;
        repeat (2) @(negedge CLK);
        N_RST = 1'b1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge CLK); #1;
            if (mode == 0) found = (n_we[0] == 3'b101 && ch[0] == 3'd1 && addr[0] == 17'd1);
            else           found = (e == n);
            if (found) break;
        end
        chk("abort_point", 64'(found), 64'd1);
        #2; N_RST = 1'b0; #1;
        chk("async_we_high", 64'(n_we[0]), 64'(3'b111));
        chk_reset("abort");
    endtask

    vec_t tbl [3];

    initial begin
        n_vec = 0; n_bad = 0; N_RST = 1'b0; fault_mode = 0;
        tbl[0] = '{0, 0, 29, 43, 9, 43, 1'b0, 0};
        tbl[1] = '{1, 1, 29, 43, 9, 48, 1'b0, 0};
        tbl[2] = '{2, 0, 29, 43, 9, 0,  1'b1, 29};

        for (int i = 0; i < 16; i++) rom_mem[i] = 8'(i + 16);

        for (int t = 0; t < 3; t++) begin
            run_load(tbl[t].fault);
            check_k(0, tbl[t].e0, 0, 1'b0, 0);
            check_k(1, tbl[t].e1, 0, 1'b0, 0);
            check_k(2, tbl[t].e2, 0, 1'b0, 0);
            check_k(3, tbl[t].e3, tbl[t].r3, tbl[t].err3, tbl[t].err_edge3);
        end

        // Reset during channel 1, word 1 strobe, then a complete reload.
        mid_reset(0, 0);
        run_load(0);
        check_k(0, 29, 0, 1'b0, 0);
        check_k(3, 43, 0, 1'b0, 0);

        // Random ROM images, some with an abort at a random edge first.
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 16; i++) rom_mem[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) mid_reset(1, int'($urandom_range(3, 25)));
            run_load(0);
            for (int k = 0; k < NK; k++) check_k(k, model_edge(k, 0), 0, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
